// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Conditional-branch resolver. It owns the condition-code register {nf, cf, zf}
// and evaluates branch conditions against it, forwarding flags written in the
// same cycle. A taken branch produces a registered one-cycle PC redirect and
// holds flush for FLUSH_DEPTH cycles.
//
// Optional feature: define FLAG_CLEAR_EN to clear the tested flag when a
// JZ/JC/JN branch is taken.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flag_we, flag_in  CCR write strobe and new flags {nf, cf, zf}
//   flag_pending      an older flag writer is in flight; branches are held off
//   br_valid, br_cond, br_target   branch request
//   br_ready          branch can be accepted this cycle
//   redirect_valid    one-cycle pulse telling fetch to load redirect_pc
//   redirect_pc       redirect target
//   flush, busy       asserted while the unit is in the FLUSH state
//   flags_out         current CCR
module branch_resolve_unit #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic [2:0]        flag_in,
    input  logic              flag_pending,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic [2:0]        flags_out,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(FLUSH_DEPTH + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [2:0]        ccr, ccr_nxt;
    logic              redirect_valid_nxt;
    logic [ADDR_W-1:0] redirect_pc_nxt;
    logic [2:0]        eff_flags;
    logic              cond_true;
    logic              accept;
    logic              take;

    // Flags seen by the branch: a same-cycle write is forwarded
    assign eff_flags = flag_we ? flag_in : ccr;

    // Condition decode against effective flags {nf, cf, zf}
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000:  cond_true = eff_flags[0];
            3'b001:  cond_true = eff_flags[1];
            3'b010:  cond_true = eff_flags[2];
            3'b011:  cond_true = 1'b1;
            3'b100:  cond_true = !eff_flags[0];
            3'b101:  cond_true = !eff_flags[1];
            3'b110:  cond_true = !eff_flags[2];
            default: cond_true = 1'b0;
        endcase
    end

    assign br_ready = (state == S_IDLE) && !flag_pending;
    assign accept   = br_valid && br_ready;
    assign take     = accept && cond_true;

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            ccr            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            ccr            <= ccr_nxt;
            redirect_valid <= redirect_valid_nxt;
            redirect_pc    <= redirect_pc_nxt;
        end
    end

    // Next-state logic; the counter exits FLUSH at zero so it never wraps
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (take) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = CNT_W'(FLUSH_DEPTH - 1);
                end
            end
            S_FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / CCR next-value logic
    always_comb begin
        redirect_valid_nxt = take;
        redirect_pc_nxt    = take ? br_target : redirect_pc;
        ccr_nxt            = flag_we ? flag_in : ccr;
`ifdef FLAG_CLEAR_EN
        // Clear only the tested bit; the rest of a coincident write survives
        if (take) begin
            case (br_cond)
                3'b000:  ccr_nxt[0] = 1'b0;
                3'b001:  ccr_nxt[1] = 1'b0;
                3'b010:  ccr_nxt[2] = 1'b0;
                default: ccr_nxt    = ccr_nxt;
            endcase
        end
`endif
    end

    assign flush     = (state == S_FLUSH);
    assign busy      = (state == S_FLUSH);
    assign flags_out = ccr;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed branch sequences; expected
// redirects (target and cycle) go into a scoreboard queue that a monitor
// drains whenever redirect_valid is seen.
module tb_branch_resolve_unit;

    localparam int unsigned AW = 16;
    localparam int unsigned FD = 3;
`ifdef FLAG_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] pc;
        int            cyc;
    } redir_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flag_we;
    logic [2:0]    flag_in;
    logic          flag_pending;
    logic          br_valid;
    logic [2:0]    br_cond;
    logic [AW-1:0] br_target;
    logic          br_ready;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          flush;
    logic [2:0]    flags_out;
    logic          busy;

    int     n_assert = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    redir_t sb_q[$];
    logic [AW-1:0] last_pc;

    branch_resolve_unit #(.ADDR_W(AW), .FLUSH_DEPTH(FD)) dut (
        .clk            (clk),
        .rst            (rst),
        .flag_we        (flag_we),
        .flag_in        (flag_in),
        .flag_pending   (flag_pending),
        .br_valid       (br_valid),
        .br_cond        (br_cond),
        .br_target      (br_target),
        .br_ready       (br_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .flags_out      (flags_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest expected one
    always @(negedge clk) begin
        if (!rst && redirect_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_redirect", 32'(redirect_pc), 32'hFFFF_FFFF);
            end else begin
                redir_t e;
                e = sb_q.pop_front();
                chk("redirect_pc", 32'(redirect_pc), 32'(e.pc));
                chk("redirect_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic idle_inputs();
        br_valid = 1'b0;
        flag_we  = 1'b0;
    endtask

    // Called at the first negedge after a taken accept
    task automatic taken_window();
        for (int k = 1; k <= int'(FD); k++) begin
            if (k > 1) @(negedge clk);
            chk("flush_hold", 32'(flush), 32'd1);
            chk("busy_hold", 32'(busy), 32'd1);
            chk("ready_in_flush", 32'(br_ready), 32'd0);
            if (k == 1) idle_inputs();
        end
        @(negedge clk);
        chk("flush_end", 32'(flush), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("ready_back", 32'(br_ready), 32'd1);
    endtask

    task automatic issue(input logic [2:0] cond, input logic [AW-1:0] tgt,
                         input logic we, input logic [2:0] fin, input bit taken);
        redir_t e;
        br_valid  = 1'b1;
        br_cond   = cond;
        br_target = tgt;
        flag_we   = we;
        flag_in   = fin;
        if (taken) begin
            e.pc  = tgt;
            e.cyc = cyc + 1;
            sb_q.push_back(e);
            last_pc = tgt;
        end
        @(negedge clk);
        if (taken) begin
            taken_window();
        end else begin
            idle_inputs();
            chk("nt_flush", 32'(flush), 32'd0);
            chk("nt_busy", 32'(busy), 32'd0);
            chk("nt_ready", 32'(br_ready), 32'd1);
            chk("nt_pc_held", 32'(redirect_pc), 32'(last_pc));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        redir_t e;
        rst = 1'b1; flag_we = 1'b0; flag_in = 3'b000; flag_pending = 1'b0;
        br_valid = 1'b0; br_cond = 3'b000; br_target = '0; last_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_flags", 32'(flags_out), 32'd0);
        chk("rst_ready", 32'(br_ready), 32'd1);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_pc", 32'(redirect_pc), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // JZ with zf written in the same cycle
        issue(3'b000, 16'h0040, 1'b1, 3'b001, 1'b1);
        chk("jz_flags", 32'(flags_out), CLR ? 32'd0 : 32'd1);

        // CCR=000: flag-true conditions not taken, JNZ taken
        flag_we = 1'b1; flag_in = 3'b000;
        @(negedge clk);
        flag_we = 1'b0;
        chk("ccr_zero", 32'(flags_out), 32'd0);
        issue(3'b001, 16'h0100, 1'b0, 3'b000, 1'b0);
        issue(3'b010, 16'h0104, 1'b0, 3'b000, 1'b0);
        issue(3'b000, 16'h0108, 1'b0, 3'b000, 1'b0);
        issue(3'b100, 16'h1234, 1'b0, 3'b000, 1'b1);

        // flag_pending holds off a JMP
        flag_pending = 1'b1;
        br_valid = 1'b1; br_cond = 3'b011; br_target = 16'h0200;
        repeat (3) begin
            @(negedge clk);
            chk("pend_ready", 32'(br_ready), 32'd0);
            chk("pend_flush", 32'(flush), 32'd0);
        end
        flag_pending = 1'b0;
        e.pc = 16'h0200; e.cyc = cyc + 1; sb_q.push_back(e); last_pc = 16'h0200;
        @(negedge clk);
        taken_window();

        // Forwarded nf makes JN taken; reserved cond never taken
        issue(3'b010, 16'h0010, 1'b1, 3'b100, 1'b1);
        chk("jn_flags", 32'(flags_out), CLR ? 32'd0 : 32'd4);
        issue(3'b111, 16'h0777, 1'b1, 3'b111, 1'b0);
        chk("rsv_flags", 32'(flags_out), 32'd7);
        issue(3'b111, 16'h0778, 1'b1, 3'b000, 1'b0);
        chk("rsv_flags0", 32'(flags_out), 32'd0);

        // Second JMP held during flush, taken FD+1 edges after the first
        br_valid = 1'b1; br_cond = 3'b011; br_target = 16'h0300;
        e.pc = 16'h0300; e.cyc = cyc + 1; sb_q.push_back(e);
        @(negedge clk);
        br_target = 16'h0400;
        for (int k = 1; k <= int'(FD); k++) begin
            if (k > 1) @(negedge clk);
            chk("b2b_ready", 32'(br_ready), 32'd0);
            chk("b2b_flush", 32'(flush), 32'd1);
        end
        @(negedge clk);
        chk("b2b_ready_back", 32'(br_ready), 32'd1);
        chk("b2b_pc_first", 32'(redirect_pc), 32'h0300);
        e.pc = 16'h0400; e.cyc = cyc + 1; sb_q.push_back(e); last_pc = 16'h0400;
        @(negedge clk);
        taken_window();

        // Reset during flush cycle 1
        flag_we = 1'b1; flag_in = 3'b110;
        @(negedge clk);
        flag_we = 1'b0;
        br_valid = 1'b1; br_cond = 3'b011; br_target = 16'h0500;
        e.pc = 16'h0500; e.cyc = cyc + 1; sb_q.push_back(e);
        @(negedge clk);
        idle_inputs();
        chk("pre_rst_flush", 32'(flush), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_flush", 32'(flush), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_redirect", 32'(redirect_valid), 32'd0);
        chk("mid_rst_flags", 32'(flags_out), 32'd0);
        chk("mid_rst_ready", 32'(br_ready), 32'd1);
        chk("mid_rst_pc", 32'(redirect_pc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_pc = '0;
        repeat (2) @(negedge clk);
        chk("post_rst_flush", 32'(flush), 32'd0);
        chk("post_rst_ready", 32'(br_ready), 32'd1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
